// File: rtl/pipe_pkg.sv
// Shared opcode/function encodings, controller state and forwarding-select
// constants for the 5-stage pipeline hazard controller.
package pipe_pkg;

    localparam logic [3:0] OP_ALU  = 4'h0;
    localparam logic [3:0] OP_BGT  = 4'h4;
    localparam logic [3:0] OP_BLT  = 4'h5;
    localparam logic [3:0] OP_BEQ  = 4'h6;
    localparam logic [3:0] OP_LW   = 4'h8;
    localparam logic [3:0] OP_SW   = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [3:0] FN_MUL = 4'h4;
    localparam logic [3:0] FN_DIV = 4'h5;

    localparam logic [15:0] INSTR_NOP = 16'h0000;

    localparam logic [1:0] FWD_REG   = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // MUL/DIV leave a second result in the rs2 field, so they write two registers.
    function automatic logic writes_reg(input logic [15:0] instr, input logic [3:0] r);
        logic is_alu;
        logic is_muldiv;
        is_alu    = (instr[15:12] == OP_ALU) && (instr != INSTR_NOP);
        is_muldiv = is_alu && ((instr[3:0] == FN_MUL) || (instr[3:0] == FN_DIV));
        return ((is_alu || (instr[15:12] == OP_LW)) && (instr[11:8] == r)) ||
               (is_muldiv && (instr[7:4] == r));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of pipeline-register instruction buses and hazard-control outputs
// exchanged between the CPU glue (master) and the hazard controller (slave).
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [15:0]      instr_id;
    logic [15:0]      instr_ex;
    logic [15:0]      instr_mem;
    logic [15:0]      instr_wb;
    logic             branch_taken_ex;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_flush;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output instr_id, instr_ex, instr_mem, instr_wb, branch_taken_ex,
        input  pc_write, ifid_write, ifid_flush, idex_flush,
        input  fwd_a, fwd_b, halted, stall_cnt, flush_cnt
    );

    modport slave (
        input  instr_id, instr_ex, instr_mem, instr_wb, branch_taken_ex,
        output pc_write, ifid_write, ifid_flush, idex_flush,
        output fwd_a, fwd_b, halted, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/fwd_unit.sv
// Combinational EX-stage forwarding select: EX/MEM wins over MEM/WB, and a
// load still in EX/MEM is skipped because its data is not available yet.
module fwd_unit (
    input  logic [3:0]  src_a,
    input  logic [3:0]  src_b,
    input  logic [15:0] instr_mem,
    input  logic [15:0] instr_wb,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b
);
    import pipe_pkg::*;

    function automatic logic [1:0] select_src(input logic [15:0] mem,
                                              input logic [15:0] wb,
                                              input logic [3:0]  r);
        if ((mem[15:12] != OP_LW) && writes_reg(mem, r)) return FWD_EXMEM;
        if (writes_reg(wb, r)) return FWD_MEMWB;
        return FWD_REG;
    endfunction

    assign fwd_a = select_src(instr_mem, instr_wb, src_a);
    assign fwd_b = select_src(instr_mem, instr_wb, src_b);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: load-use stalls,
// branch/jump flushes, forwarding selects, halt drain and saturating counters.
module pipeline_hazard_ctrl #(
    parameter int CNT_W        = 16,
    parameter int DRAIN_CYCLES = 3
) (
    input logic                   clk,
    input logic                   rst,
    pipeline_hazard_ctrl_if.slave bus
);
    import pipe_pkg::*;

    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    state_t           state;
    logic [DW-1:0]    drain_ctr;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    logic       running;
    logic       load_use;
    logic       take_branch;
    logic       take_stall;
    logic       take_jmp;
    logic       take_halt;
    logic [1:0] fwd_a_raw;
    logic [1:0] fwd_b_raw;
    logic       unused_bits;

    assign running  = (state == ST_RUN);
    assign load_use = (bus.instr_ex[15:12] == OP_LW) &&
                      ((bus.instr_ex[11:8] == bus.instr_id[11:8]) ||
                       (bus.instr_ex[11:8] == bus.instr_id[7:4]));

    // Only the oldest event in a cycle acts; younger ones are squashed or retried.
    assign take_branch = running && bus.branch_taken_ex;
    assign take_stall  = running && !bus.branch_taken_ex && load_use;
    assign take_jmp    = running && !bus.branch_taken_ex && !load_use &&
                         (bus.instr_id[15:12] == OP_JMP);
    assign take_halt   = running && !bus.branch_taken_ex && !load_use &&
                         (bus.instr_id[15:12] == OP_HALT);

    assign unused_bits = ^{bus.instr_id[3:0], bus.instr_ex[3:0]};

    fwd_unit u_fwd (
        .src_a     (bus.instr_ex[11:8]),
        .src_b     (bus.instr_ex[7:4]),
        .instr_mem (bus.instr_mem),
        .instr_wb  (bus.instr_wb),
        .fwd_a     (fwd_a_raw),
        .fwd_b     (fwd_b_raw)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_RUN;
            drain_ctr <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (take_branch || take_jmp) begin
                        if (flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
                    end else if (take_stall) begin
                        if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
                    end else if (take_halt) begin
                        state     <= ST_DRAIN;
                        drain_ctr <= DW'(DRAIN_CYCLES);
                    end
                end
                ST_DRAIN: begin
                    if (drain_ctr == DW'(1)) state <= ST_HALTED;
                    drain_ctr <= drain_ctr - DW'(1);
                end
                ST_HALTED: begin
                    state <= ST_HALTED;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    // While reset is held the front end is frozen and both pipeline registers flush.
    always_comb begin
        bus.pc_write   = 1'b0;
        bus.ifid_write = 1'b0;
        bus.ifid_flush = 1'b1;
        bus.idex_flush = 1'b1;
        if (rst) begin
            bus.ifid_flush = 1'b0;
            bus.idex_flush = 1'b0;
            if (!running) begin
                bus.idex_flush = 1'b1;
            end else if (take_branch) begin
                bus.pc_write   = 1'b1;
                bus.ifid_write = 1'b1;
                bus.ifid_flush = 1'b1;
                bus.idex_flush = 1'b1;
            end else if (take_stall) begin
                bus.idex_flush = 1'b1;
            end else if (take_jmp) begin
                bus.pc_write   = 1'b1;
                bus.ifid_write = 1'b1;
                bus.ifid_flush = 1'b1;
            end else if (!take_halt) begin
                bus.pc_write   = 1'b1;
                bus.ifid_write = 1'b1;
            end
        end
    end

    assign bus.fwd_a     = rst ? fwd_a_raw : FWD_REG;
    assign bus.fwd_b     = rst ? fwd_b_raw : FWD_REG;
    assign bus.halted    = (state == ST_HALTED);
    assign bus.stall_cnt = stall_cnt;
    assign bus.flush_cnt = flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed hazard scenarios plus
// randomized instruction mixes checked against a cycle-indexed reference model.
module tb_pipeline_hazard_ctrl;
    import pipe_pkg::*;

    localparam int CNT_W        = 16;
    localparam int DRAIN_CYCLES = 3;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [15:0] NOP = 16'h0000;

    typedef struct {
        int               cyc;
        logic             pc_write;
        logic             ifid_write;
        logic             ifid_flush;
        logic             idex_flush;
        logic [1:0]       fwd_a;
        logic [1:0]       fwd_b;
        logic             halted;
        logic [CNT_W-1:0] stall_cnt;
        logic [CNT_W-1:0] flush_cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_hazard_ctrl #(
        .CNT_W        (CNT_W),
        .DRAIN_CYCLES (DRAIN_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb[$];
    int checks = 0;
    int passes = 0;

    // Reference model state: the cycle a HALT was accepted stands in for the FSM.
    int               cyc;
    int               halt_at;
    logic [CNT_W-1:0] m_stall;
    logic [CNT_W-1:0] m_flush;

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [3:0] a,
                                       input logic [3:0] b, input logic [3:0] f);
        return {op, a, b, f};
    endfunction

    function automatic bit writes(input logic [15:0] ins, input logic [3:0] r);
        if (ins == NOP) return 1'b0;
        case (ins[15:12])
            OP_LW:  return ins[11:8] == r;
            OP_ALU: return (ins[11:8] == r) ||
                           (((ins[3:0] == FN_MUL) || (ins[3:0] == FN_DIV)) && ins[7:4] == r);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] fwd_src(input logic [15:0] mem, input logic [15:0] wb,
                                           input logic [3:0] r);
        if (mem[15:12] != OP_LW && writes(mem, r)) return 2'd1;
        if (writes(wb, r)) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    function automatic logic [15:0] rand_instr();
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] f;
        a = 4'($urandom_range(0, 3));
        b = 4'($urandom_range(0, 3));
        f = 4'($urandom_range(0, 15));
        case ($urandom_range(0, 9))
            0, 1: return mk(OP_ALU, a, b, f);
            2:    return mk(OP_ALU, a, b, FN_MUL);
            3:    return mk(OP_ALU, a, b, FN_DIV);
            4, 5: return mk(OP_LW, a, b, f);
            6:    return mk(OP_SW, a, b, f);
            7:    return mk(OP_BEQ, a, b, f);
            8:    return NOP;
            default: return mk(OP_JMP, a, b, f);
        endcase
    endfunction

    task automatic apply_stimulus(input logic rst_v, input logic [15:0] id,
                                  input logic [15:0] ex, input logic [15:0] mem,
                                  input logic [15:0] wb, input logic br, input bit check);
        exp_t e;
        bit   is_halted;
        bit   is_draining;
        bit   lu;
        @(posedge clk);
        #1;
        rst                 = rst_v;
        bus.instr_id        = id;
        bus.instr_ex        = ex;
        bus.instr_mem       = mem;
        bus.instr_wb        = wb;
        bus.branch_taken_ex = br;
        e.cyc = cyc;
        if (!rst_v) begin
            halt_at = -1;
            m_stall = '0;
            m_flush = '0;
            e.pc_write = 1'b0; e.ifid_write = 1'b0; e.ifid_flush = 1'b1; e.idex_flush = 1'b1;
            e.fwd_a = 2'd0; e.fwd_b = 2'd0; e.halted = 1'b0;
            e.stall_cnt = '0; e.flush_cnt = '0;
        end else begin
            is_halted   = (halt_at >= 0) && (cyc >= halt_at + 1 + DRAIN_CYCLES);
            is_draining = (halt_at >= 0) && !is_halted;
            e.halted    = is_halted;
            e.stall_cnt = m_stall;
            e.flush_cnt = m_flush;
            e.fwd_a     = fwd_src(mem, wb, ex[11:8]);
            e.fwd_b     = fwd_src(mem, wb, ex[7:4]);
            e.pc_write = 1'b1; e.ifid_write = 1'b1; e.ifid_flush = 1'b0; e.idex_flush = 1'b0;
            if (is_halted || is_draining) begin
                e.pc_write = 1'b0; e.ifid_write = 1'b0; e.idex_flush = 1'b1;
            end else begin
                lu = (ex[15:12] == OP_LW) && ((ex[11:8] == id[11:8]) || (ex[11:8] == id[7:4]));
                if (br) begin
                    e.ifid_flush = 1'b1; e.idex_flush = 1'b1;
                    m_flush = sat_inc(m_flush);
                end else if (lu) begin
                    e.pc_write = 1'b0; e.ifid_write = 1'b0; e.idex_flush = 1'b1;
                    m_stall = sat_inc(m_stall);
                end else if (id[15:12] == OP_JMP) begin
                    e.ifid_flush = 1'b1;
                    m_flush = sat_inc(m_flush);
                end else if (id[15:12] == OP_HALT) begin
                    e.pc_write = 1'b0; e.ifid_write = 1'b0;
                    halt_at = cyc;
                end
            end
        end
        if (check) sb.push_back(e);
        cyc++;
    endtask

    task automatic check_output(input string name, input int c,
                                input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act === want) passes++;
        else $display("[TB] FAIL %s cycle %0d: got %0h, want %0h", name, c, act, want);
    endtask

    // Monitor: compares the DUT's settled outputs mid-cycle against the queued model result.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_output("pc_write",   e.cyc, 32'(bus.pc_write),   32'(e.pc_write));
            check_output("ifid_write", e.cyc, 32'(bus.ifid_write), 32'(e.ifid_write));
            check_output("ifid_flush", e.cyc, 32'(bus.ifid_flush), 32'(e.ifid_flush));
            check_output("idex_flush", e.cyc, 32'(bus.idex_flush), 32'(e.idex_flush));
            check_output("fwd_a",      e.cyc, 32'(bus.fwd_a),      32'(e.fwd_a));
            check_output("fwd_b",      e.cyc, 32'(bus.fwd_b),      32'(e.fwd_b));
            check_output("halted",     e.cyc, 32'(bus.halted),     32'(e.halted));
            check_output("stall_cnt",  e.cyc, 32'(bus.stall_cnt),  32'(e.stall_cnt));
            check_output("flush_cnt",  e.cyc, 32'(bus.flush_cnt),  32'(e.flush_cnt));
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0;
        bus.instr_id = NOP; bus.instr_ex = NOP; bus.instr_mem = NOP; bus.instr_wb = NOP;
        bus.branch_taken_ex = 1'b0;
        cyc = 0; halt_at = -1; m_stall = '0; m_flush = '0;

        $display("[TB] reset and forwarding");
        apply_stimulus(1'b0, NOP, NOP, NOP, NOP, 1'b0, 1'b1);
        apply_stimulus(1'b0, NOP, mk(OP_SW, 1, 5, 0), mk(OP_ALU, 1, 2, 3), NOP, 1'b0, 1'b1);
        apply_stimulus(1'b1, NOP, mk(OP_SW, 1, 5, 0), mk(OP_ALU, 1, 2, 3), NOP, 1'b0, 1'b1);
        apply_stimulus(1'b1, NOP, mk(OP_SW, 1, 5, 0), NOP, mk(OP_ALU, 1, 2, 3), 1'b0, 1'b1);
        apply_stimulus(1'b1, NOP, mk(OP_SW, 1, 5, 0), mk(OP_ALU, 1, 2, 3), mk(OP_ALU, 1, 6, 7), 1'b0, 1'b1);

        $display("[TB] load-use, MUL forwarding, branch over HALT, JMP");
        apply_stimulus(1'b1, mk(OP_ALU, 5, 2, 0), mk(OP_LW, 2, 3, 0), NOP, NOP, 1'b0, 1'b1);
        apply_stimulus(1'b1, mk(OP_ALU, 5, 2, 0), NOP, mk(OP_LW, 2, 3, 0), NOP, 1'b0, 1'b1);
        apply_stimulus(1'b1, NOP, mk(OP_ALU, 6, 4, 0), mk(OP_ALU, 3, 4, FN_MUL), NOP, 1'b0, 1'b1);
        apply_stimulus(1'b1, NOP, mk(OP_ALU, 6, 4, 0), mk(OP_LW, 4, 0, 0), NOP, 1'b0, 1'b1);
        apply_stimulus(1'b1, mk(OP_HALT, 0, 0, 0), mk(OP_BEQ, 1, 2, 0), NOP, NOP, 1'b1, 1'b1);
        apply_stimulus(1'b1, NOP, NOP, NOP, NOP, 1'b0, 1'b1);
        apply_stimulus(1'b1, mk(OP_JMP, 0, 0, 8), NOP, NOP, NOP, 1'b0, 1'b1);
        apply_stimulus(1'b1, mk(OP_JMP, 2, 0, 8), mk(OP_LW, 2, 0, 0), NOP, NOP, 1'b0, 1'b1);

        $display("[TB] randomized instruction mix");
        for (int i = 0; i < 300; i++) begin
            apply_stimulus(1'b1, rand_instr(), rand_instr(), rand_instr(), rand_instr(),
                           ($urandom_range(0, 4) == 0), 1'b1);
        end

        $display("[TB] halt drain timing");
        apply_stimulus(1'b0, NOP, NOP, NOP, NOP, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) apply_stimulus(1'b1, NOP, NOP, NOP, NOP, 1'b0, 1'b1);
        apply_stimulus(1'b1, mk(OP_HALT, 0, 0, 0), NOP, NOP, NOP, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b1, mk(OP_HALT, 2, 0, 0), mk(OP_LW, 2, 1, 0),
                           rand_instr(), rand_instr(), (i == 1 || i == 6), 1'b1);
        end

        $display("[TB] reset during drain");
        apply_stimulus(1'b0, NOP, NOP, NOP, NOP, 1'b0, 1'b1);
        apply_stimulus(1'b1, mk(OP_JMP, 0, 0, 1), NOP, NOP, NOP, 1'b0, 1'b1);
        apply_stimulus(1'b1, mk(OP_ALU, 3, 1, 0), mk(OP_LW, 3, 0, 0), NOP, NOP, 1'b0, 1'b1);
        apply_stimulus(1'b1, mk(OP_HALT, 0, 0, 0), NOP, NOP, NOP, 1'b0, 1'b1);
        apply_stimulus(1'b1, NOP, NOP, NOP, NOP, 1'b0, 1'b1);
        apply_stimulus(1'b1, NOP, NOP, NOP, NOP, 1'b0, 1'b1);
        apply_stimulus(1'b0, NOP, NOP, NOP, NOP, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, NOP, NOP, NOP, NOP, 1'b0, 1'b1);

        $display("[TB] stall counter saturation");
        apply_stimulus(1'b0, NOP, NOP, NOP, NOP, 1'b0, 1'b1);
        for (int i = 0; i < 65538; i++) begin
            apply_stimulus(1'b1, mk(OP_ALU, 5, 2, 0), mk(OP_LW, 2, 3, 0), NOP, NOP, 1'b0,
                           (i >= 65532));
        end
        apply_stimulus(1'b1, NOP, NOP, NOP, NOP, 1'b0, 1'b1);

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            checks++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage 16-bit pipeline (IF, ID, EX, MEM, WB).
- Inspects the instruction word held in each pipeline register and drives PC/IF-ID write enables, pipeline-register flushes and EX-stage forwarding selects.
- Owns the halt-drain state machine and two 16-bit performance counters.
- Sits beside CPU-level glue. Consumes IF/ID, ID/EX, EX/MEM and MEM/WB instruction buses plus the EX-stage branch result.

Parameters:
- CNT_W, 16, width of the stall and flush performance counters (saturating).
- DRAIN_CYCLES, 3, cycles for a halt in ID to reach WB.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-low reset.
- instr_id  in  16  IF/ID instruction.
- instr_ex  in  16  ID/EX instruction.
- instr_mem  in  16  EX/MEM instruction.
- instr_wb  in  16  MEM/WB instruction.
- branch_taken_ex  in  1  branch in EX resolved taken.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_flush  out  1  ID/EX loads a bubble.
- fwd_a  out  2  EX operand A source (0 reg, 1 EX/MEM, 2 MEM/WB).
- fwd_b  out  2  EX operand B source, same encoding.
- halted  out  1  pipeline drained after HALT.
- stall_cnt  out  CNT_W  load-use stall cycles.
- flush_cnt  out  CNT_W  flush events.

Behaviour:
- Instruction fields: opcode [15:12]; rd/rs1 [11:8]; rs2 [7:4]; funct [3:0].
- Register writers: ALU and LW write [11:8]. MUL/DIV (opcode ALU, funct MUL/DIV) also write [7:4].
- Non-writers: SW, branches, JMP, HALT and NOP (16'h0000).
- Forwarding (combinational, all 16 registers):
  - fwd_a compares instr_ex[11:8]; fwd_b compares instr_ex[7:4].
  - EX/MEM writer match gives 1, else MEM/WB writer match gives 2, else 0. EX/MEM has priority.
  - A LW in EX/MEM is never a forward source (its data is not yet valid). Return 0 for that stage and fall back to the MEM/WB check.
- Load-use: instr_ex is LW and its [11:8] equals instr_id[11:8] or instr_id[7:4].
  - Response: pc_write=0, ifid_write=0, idex_flush=1 for exactly one cycle; stall_cnt++.
- Branch taken (branch_taken_ex=1): ifid_flush=1, idex_flush=1, pc_write=1 (PC takes target); flush_cnt++. Penalty is 2 cycles.
- JMP in ID: ifid_flush=1, pc_write=1; flush_cnt++.
- Priority within a cycle: branch_taken_ex > load-use > JMP in ID > HALT in ID. Lower-priority younger events are squashed or deferred.
- FSM states: RUN, DRAIN, HALTED. Encodings are held in the package.
  - RUN: default. If HALT is in ID with no higher event, hold pc_write=0 and ifid_write=0 that cycle, then go to DRAIN with drain_ctr=DRAIN_CYCLES.
  - DRAIN: pc_write=0, ifid_write=0, idex_flush=1. Forwarding stays live. drain_ctr decrements each cycle; at 1, go to HALTED.
  - HALTED: halted=1, pc_write=0, ifid_write=0, idex_flush=1. Left only by reset.
- Timing example: HALT in ID at cycle t gives halted=1 from t+4.
- Counters saturate at all-ones and do not wrap. Neither counter increments in DRAIN or HALTED.
- Reset (rst=0, asynchronous): state=RUN, drain_ctr=0, counters=0, halted=0.
  - Outputs while in reset: pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, fwd_a=fwd_b=0.
  - A reset during DRAIN returns to RUN immediately.
- Only the FSM, drain_ctr and the counters are registered. All other outputs are combinational from the current state and inputs.

Decomposition:
- Package pipe_pkg holds:
  - Opcodes: OP_ALU=4'h0, OP_LW=4'h8, OP_SW=4'hB, OP_BLT=4'h5, OP_BGT=4'h4, OP_BEQ=4'h6, OP_JMP=4'hC, OP_HALT=4'hF.
  - Function codes: FN_MUL=4'h4, FN_DIV=4'h5.
  - FSM state encodings and the fwd select constants.
- Sub-module fwd_unit: purely combinational forwarding compare, instantiated once and producing fwd_a/fwd_b.

Test Plan:
- ADD R1 in MEM, consumer using R1 as rs1 in EX → fwd_a=1. Same writer in WB only → fwd_a=2. Both stages write R1 → fwd_a=1.
- LW R2 in EX, ID reads R2 as rs2 → one cycle of pc_write=0, ifid_write=0, idex_flush=1; stall_cnt 0→1; next cycle normal.
- MUL R3,R4 in MEM; EX reads R4 in [7:4] → fwd_b=1. LW R4 in MEM instead → fwd_b=0.
- branch_taken_ex=1 while HALT is in ID → ifid_flush=idex_flush=1, no DRAIN entry, flush_cnt=1.
- HALT in ID at cycle 10 → pc_write=0 from cycle 10, halted=1 at cycle 14 and held.
- Drive rst low in DRAIN and release → state RUN, halted=0, counters 0. Preload stall_cnt to 16'hFFFF and force a load-use → stays 16'hFFFF.
